noc_peek_uart_streamer: RTL and testbench

Dumps core memories over the serial link. On a start pulse it walks the peek port of noc_with_cores across a range of node IDs and word addresses. Each 32-bit word is captured and handed byte-by-byte to the UART transmitter through its valid/ready byte interface. The block sits between the peek port of noc_with_cores and the TX side of uart, and replaces ad-hoc scan logic at top level.

---
 rtl/noc_peek_uart_streamer_if.sv | 26 ++
 rtl/noc_peek_uart_streamer.sv | 162 ++++++++++++++++
 tb/tb_noc_peek_uart_streamer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_peek_uart_streamer_if.sv
// Purpose: bundles the start/status, peek-port and UART-TX byte signals of noc_peek_uart_streamer.
// Ports: start/busy/done control; peekId/peekAddress out and peekData in; dataToTX/validIn out and txReady in.
// master = the streamer side, slave = the environment (core control, noc_with_cores peek port, uart TX).
interface noc_peek_uart_streamer_if #(
  parameter int ID_W = 4
);
  logic            start;
  logic            busy;
  logic            done;
  logic [ID_W-1:0] peekId;
  logic [31:0]     peekAddress;
  logic [31:0]     peekData;
  logic [7:0]      dataToTX;
  logic            validIn;
  logic            txReady;

  modport master (
    input  start, peekData, txReady,
    output busy, done, peekId, peekAddress, dataToTX, validIn
  );

  modport slave (
    output start, peekData, txReady,
    input  busy, done, peekId, peekAddress, dataToTX, validIn
  );
endinterface

// File: rtl/noc_peek_uart_streamer.sv
// Purpose: on start, walks the peek port over nodes FIRST_ID..LAST_ID and words 0..WORDS-1 and streams
//          per node a 0xA5 sync byte, the node ID byte, then every word little-endian to the UART TX.
// Ports: clk, rst (async, active-high); bus (master modport) carries start/busy/done, peek port, TX byte port.
// Latency: PEEK_LAT+1 cycles per word fetch; bytes move at up to one per cycle, holding while txReady is low.
module noc_peek_uart_streamer #(
  parameter int ID_W     = 4,
  parameter int FIRST_ID = 0,
  parameter int LAST_ID  = 15,
  parameter int WORDS    = 1024,
  parameter int PEEK_LAT = 1
) (
  input logic clk,
  input logic rst,
  noc_peek_uart_streamer_if.master bus
);

  localparam logic [ID_W-1:0] FIRST     = ID_W'(FIRST_ID);
  localparam logic [ID_W-1:0] LAST      = ID_W'(LAST_ID);
  localparam logic [31:0]     LAST_ADDR = 32'(WORDS - 1);
  localparam logic [1:0]      LAT       = 2'(PEEK_LAT);
  localparam logic [7:0]      SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {IDLE, HDR_SYNC, HDR_ID, FETCH, SEND, NEXT} state_t;

  state_t          state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            vld_q, vld_d;
  logic [7:0]      dat_q, dat_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     word_q, word_d;
  logic [1:0]      byte_q, byte_d;
  logic [1:0]      wait_q, wait_d;

  logic            xfer;
  logic [1:0]      byte_nx;

  assign xfer    = vld_q && bus.txReady;
  assign byte_nx = byte_q + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
      dat_q   <= 8'h00;
      id_q    <= FIRST;
      addr_q  <= 32'd0;
      word_q  <= 32'd0;
      byte_q  <= 2'd0;
      wait_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    vld_d   = vld_q;
    dat_d   = dat_q;
    id_d    = id_q;
    addr_d  = addr_q;
    word_d  = word_q;
    byte_d  = byte_q;
    wait_d  = wait_q;

    case (state_q)
      IDLE: begin
        // busy is still high during the done cycle; a start seen then is dropped.
        busy_d = 1'b0;
        if (bus.start && !done_q) begin
          state_d = HDR_SYNC;
          busy_d  = 1'b1;
          id_d    = FIRST;
          addr_d  = 32'd0;
          vld_d   = 1'b1;
          dat_d   = SYNC_BYTE;
        end
      end
      HDR_SYNC: begin
        if (xfer) begin
          state_d = HDR_ID;
          dat_d   = 8'(id_q);
        end
      end
      HDR_ID: begin
        if (xfer) begin
          state_d = FETCH;
          vld_d   = 1'b0;
          wait_d  = 2'd0;
        end
      end
      FETCH: begin
        // Peek port has had PEEK_LAT stable cycles: capture the word and present its low byte.
        if (wait_q == LAT) begin
          state_d = SEND;
          word_d  = bus.peekData;
          byte_d  = 2'd0;
          vld_d   = 1'b1;
          dat_d   = bus.peekData[7:0];
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      SEND: begin
        if (xfer) begin
          if (byte_q == 2'd3) begin
            state_d = NEXT;
            vld_d   = 1'b0;
          end else begin
            byte_d = byte_nx;
            case (byte_nx)
              2'd1:    dat_d = word_q[15:8];
              2'd2:    dat_d = word_q[23:16];
              default: dat_d = word_q[31:24];
            endcase
          end
        end
      end
      NEXT: begin
        if (addr_q < LAST_ADDR) begin
          state_d = FETCH;
          addr_d  = addr_q + 32'd1;
          wait_d  = 2'd0;
        end else if (id_q < LAST) begin
          state_d = HDR_SYNC;
          id_d    = id_q + 1'b1;
          addr_d  = 32'd0;
          vld_d   = 1'b1;
          dat_d   = SYNC_BYTE;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          id_d    = FIRST;
          addr_d  = 32'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.validIn     = vld_q;
  assign bus.dataToTX    = dat_q;
  assign bus.peekId      = id_q;
  assign bus.peekAddress = addr_q;

endmodule

// File: tb/tb_noc_peek_uart_streamer.sv
// Bench for noc_peek_uart_streamer: two instances (A: node 3 only, 2 words, PEEK_LAT=1;
// B: nodes 0..1, 1 word, PEEK_LAT=3). Expected byte streams are queued when a dump is started and
// a per-instance monitor pops and compares on every validIn && txReady transfer.
module tb_noc_peek_uart_streamer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic tx_rdy = 1'b0;
  int   mode = 0;        // 0: txReady high, 1: pattern 1,0,0, 2: txReady low
  int   ph = 0;
  int   checks = 0;
  int   errors = 0;
  int   xfer_a = 0;
  int   done_exp_a = 0;
  int   done_exp_b = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [31:0] cyc = 32'd0;

  logic [7:0] stream_a [10] = '{8'hA5, 8'h03, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
  logic [7:0] stream_b [12] = '{8'hA5, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA,
                                8'hA5, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'h0B};

  always #5 clk = ~clk;

  noc_peek_uart_streamer_if #(.ID_W(4)) ifa ();
  noc_peek_uart_streamer_if #(.ID_W(4)) ifb ();

  noc_peek_uart_streamer #(.ID_W(4), .FIRST_ID(3), .LAST_ID(3), .WORDS(2), .PEEK_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.master));
  noc_peek_uart_streamer #(.ID_W(4), .FIRST_ID(0), .LAST_ID(1), .WORDS(1), .PEEK_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.master));

  assign ifa.start   = start_a;
  assign ifb.start   = start_b;
  assign ifa.txReady = tx_rdy;
  assign ifb.txReady = tx_rdy;

  function automatic logic [31:0] mem_a(input logic [3:0] id, input logic [31:0] a);
    if (id == 4'd3 && a == 32'd0) return 32'h11223344;
    if (id == 4'd3 && a == 32'd1) return 32'hAABBCCDD;
    return 32'hDEAD0000;
  endfunction

  function automatic logic [31:0] mem_b(input logic [3:0] id, input logic [31:0] a);
    if (id == 4'd0 && a == 32'd0) return 32'hCAFEF00D;
    if (id == 4'd1 && a == 32'd0) return 32'h0BADBEEF;
    return 32'hDEAD0001;
  endfunction

  // Peek port model: the true word is presented only exactly PEEK_LAT cycles after the address
  // settles (first cycle with validIn low and an unchanged address); any other cycle shows junk.
  wire [31:0] junk = (cyc * 32'h9E3779B9) ^ 32'h5A5A5A5A;
  logic [35:0] prev_a = '0, prev_b = '0;
  logic prev_vld_a = 1'b0, prev_vld_b = 1'b0;
  int run_a = 0, run_b = 0, run_now_a, run_now_b;

  always_comb run_now_a = (({ifa.peekId, ifa.peekAddress} != prev_a) || prev_vld_a) ? 0 : run_a + 1;
  always_comb run_now_b = (({ifb.peekId, ifb.peekAddress} != prev_b) || prev_vld_b) ? 0 : run_b + 1;
  assign ifa.peekData = (!ifa.validIn && run_now_a == 1) ? mem_a(ifa.peekId, ifa.peekAddress) : junk;
  assign ifb.peekData = (!ifb.validIn && run_now_b == 3) ? mem_b(ifb.peekId, ifb.peekAddress) : junk;

  initial forever begin
    @(posedge clk);
    cyc        <= cyc + 32'd1;
    prev_a     <= {ifa.peekId, ifa.peekAddress};
    prev_b     <= {ifb.peekId, ifb.peekAddress};
    prev_vld_a <= ifa.validIn;
    prev_vld_b <= ifb.validIn;
    run_a      <= (run_now_a > 100) ? 100 : run_now_a;
    run_b      <= (run_now_b > 100) ? 100 : run_now_b;
  end

  // txReady driver
  initial forever begin
    @(posedge clk); #1;
    case (mode)
      0:       tx_rdy = 1'b1;
      1:       tx_rdy = (ph == 0);
      default: tx_rdy = 1'b0;
    endcase
    ph = (ph + 1) % 3;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor A
  initial begin
    logic       stall = 1'b0;
    logic [7:0] stall_dat = 8'h00;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("a_hold_valid", 32'(ifa.validIn), 32'd1);
          chk("a_hold_data", 32'(ifa.dataToTX), 32'(stall_dat));
        end
        if (ifa.validIn && ifa.txReady) begin
          xfer_a++;
          chk("a_busy_on_xfer", 32'(ifa.busy), 32'd1);
          if (q_a.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_extra_byte: got 0x%0h, expected no transfer", ifa.dataToTX);
          end else begin
            chk("a_byte", 32'(ifa.dataToTX), 32'(q_a.pop_front()));
          end
        end
        if (ifa.done) begin
          chk("a_done_expected", 32'(done_exp_a > 0), 32'd1);
          chk("a_done_all_bytes", 32'(q_a.size()), 32'd0);
          chk("a_busy_with_done", 32'(ifa.busy), 32'd1);
          if (done_exp_a > 0) done_exp_a--;
        end
        stall = ifa.validIn && !ifa.txReady;
        stall_dat = ifa.dataToTX;
      end
    end
  end

  // Monitor B
  initial begin
    logic       stall = 1'b0;
    logic [7:0] stall_dat = 8'h00;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("b_hold_valid", 32'(ifb.validIn), 32'd1);
          chk("b_hold_data", 32'(ifb.dataToTX), 32'(stall_dat));
        end
        if (ifb.validIn && ifb.txReady) begin
          chk("b_busy_on_xfer", 32'(ifb.busy), 32'd1);
          chk("b_addr_zero", ifb.peekAddress, 32'd0);
          if (q_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_extra_byte: got 0x%0h, expected no transfer", ifb.dataToTX);
          end else begin
            chk("b_byte", 32'(ifb.dataToTX), 32'(q_b.pop_front()));
          end
        end
        if (ifb.done) begin
          chk("b_done_expected", 32'(done_exp_b > 0), 32'd1);
          chk("b_done_all_bytes", 32'(q_b.size()), 32'd0);
          chk("b_busy_with_done", 32'(ifb.busy), 32'd1);
          if (done_exp_b > 0) done_exp_b--;
        end
        stall = ifb.validIn && !ifb.txReady;
        stall_dat = ifb.dataToTX;
      end
    end
  end

  task automatic push_a();
    foreach (stream_a[i]) q_a.push_back(stream_a[i]);
    done_exp_a++;
  endtask

  task automatic push_b();
    foreach (stream_b[i]) q_b.push_back(stream_b[i]);
    done_exp_b++;
  endtask

  task automatic pulse(input int which);
    @(posedge clk); #1;
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    chk(which ? "b_busy_after_start" : "a_busy_after_start", 32'(which ? ifb.busy : ifa.busy), 32'd1);
  endtask

  task automatic wait_done(input int which, input string name);
    int i = 0;
    while (i < 400 && !(which ? ifb.done : ifa.done)) begin
      @(negedge clk);
      i++;
    end
    chk(name, 32'(which ? ifb.done : ifa.done), 32'd1);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_busy"},  32'(ifa.busy), 32'd0);
    chk({tag, "_done"},  32'(ifa.done), 32'd0);
    chk({tag, "_valid"}, 32'(ifa.validIn), 32'd0);
    chk({tag, "_data"},  32'(ifa.dataToTX), 32'd0);
    chk({tag, "_id"},    32'(ifa.peekId), 32'd3);
    chk({tag, "_addr"},  ifa.peekAddress, 32'd0);
  endtask

  initial begin
    int i;
    int base;
    // Reset values
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_a("reset_a");
    chk("reset_b_id", 32'(ifb.peekId), 32'd0);
    chk("reset_b_valid", 32'(ifb.validIn), 32'd0);
    @(posedge clk); #2 rst = 1'b0;

    // Full-rate dump on A: 10 bytes, single done pulse
    mode = 0;
    base = xfer_a;
    push_a();
    pulse(0);
    wait_done(0, "a_fullrate_done");
    @(negedge clk);
    chk("a_done_one_cycle", 32'(ifa.done), 32'd0);
    chk("a_xfer_count", 32'(xfer_a - base), 32'd10);

    // Same dump with txReady toggling 1,0,0
    mode = 1;
    push_a();
    pulse(0);
    wait_done(0, "a_toggle_done");

    // Start during busy and in the done cycle are ignored; start one cycle after done is taken
    mode = 0;
    push_a();
    pulse(0);
    repeat (3) @(negedge clk);
    pulse(0);
    wait_done(0, "a_restart_done");
    start_a = 1'b1;
    @(posedge clk); #1;
    chk("a_busy_after_done_start", 32'(ifa.busy), 32'd0);
    chk("a_done_cleared", 32'(ifa.done), 32'd0);
    push_a();
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("a_busy_new_dump", 32'(ifa.busy), 32'd1);
    wait_done(0, "a_second_dump_done");

    // Reset while a SEND byte is stalled
    push_a();
    pulse(0);
    i = 0;
    while (i < 100 && !(ifa.busy && !ifa.validIn)) begin @(negedge clk); i++; end
    chk("a_reach_fetch", 32'(ifa.busy && !ifa.validIn), 32'd1);
    mode = 2;
    i = 0;
    while (i < 100 && !(ifa.validIn && ifa.dataToTX == 8'h44)) begin @(negedge clk); i++; end
    chk("a_reach_send", 32'(ifa.validIn && ifa.dataToTX == 8'h44), 32'd1);
    #2 rst = 1'b1;
    q_a.delete();
    done_exp_a = 0;
    #1;
    chk_reset_a("abort_a");
    @(posedge clk);
    @(posedge clk); #2 rst = 1'b0;
    mode = 0;
    repeat (20) @(negedge clk);
    chk("a_idle_after_abort", 32'(ifa.busy), 32'd0);

    // B: two nodes, one word each, PEEK_LAT=3, toggling txReady
    mode = 1;
    push_b();
    pulse(1);
    wait_done(1, "b_done");
    chk("b_id_after_done", 32'(ifb.peekId), 32'd0);
    chk("b_addr_after_done", ifb.peekAddress, 32'd0);

    mode = 0;
    repeat (10) @(negedge clk);
    chk("a_queue_drained", 32'(q_a.size()), 32'd0);
    chk("b_queue_drained", 32'(q_b.size()), 32'd0);
    chk("a_done_count", 32'(done_exp_a), 32'd0);
    chk("b_done_count", 32'(done_exp_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
